// File: rtl/fifo_demux_pkg.sv
// Shared definitions for the fifo_demux_p packet demultiplexer.
package fifo_demux_pkg;

    // Destination channel encoding carried on din_chan.
    typedef enum logic [1:0] {
        CHAN_A   = 2'd0,
        CHAN_B   = 2'd1,
        CHAN_C   = 2'd2,
        CHAN_BAD = 2'd3
    } chan_e;

    localparam int unsigned W_A = 8;
    localparam int unsigned W_B = 16;
    localparam int unsigned W_C = 32;

    // Empty-byte count of a 32-bit word whose upper half-word is absent.
    localparam logic [1:0] MTY_HALF = 2'd2;

endpackage

// File: rtl/fifo_demux_pack32.sv
// Channel-2 16->32 packer: pairs half-words, first half-word in [15:0].
module fifo_demux_pack32
    import fifo_demux_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    input  logic [W_B-1:0] in_data,
    input  logic           in_sop,
    input  logic           in_eop,
    input  logic           in_mty,
    input  logic           flush,
    output logic [W_C-1:0] out_data,
    output logic           out_sop,
    output logic           out_eop,
    output logic [1:0]     out_mty,
    output logic           out_vld
);

    logic [W_B-1:0] lo_reg;
    logic           lo_vld;
    logic           lo_sop;
    logic           lo_live;

    // A flush discards the held half-word before the same-cycle beat is considered.
    assign lo_live = lo_vld && !flush;

    // Hold the first half-word, emit on the second or on an early eop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg   <= '0;
            lo_vld   <= 1'b0;
            lo_sop   <= 1'b0;
            out_data <= '0;
            out_sop  <= 1'b0;
            out_eop  <= 1'b0;
            out_mty  <= '0;
            out_vld  <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            out_sop <= 1'b0;
            out_eop <= 1'b0;
            if (flush) begin
                lo_vld <= 1'b0;
            end
            if (in_vld) begin
                if (lo_live) begin
                    out_data <= {in_data, lo_reg};
                    out_vld  <= 1'b1;
                    out_sop  <= lo_sop;
                    out_eop  <= in_eop;
                    out_mty  <= in_eop ? {1'b0, in_mty} : 2'd0;
                    lo_vld   <= 1'b0;
                end else if (in_eop) begin
                    out_data <= {{(W_C - W_B){1'b0}}, in_data};
                    out_vld  <= 1'b1;
                    out_sop  <= in_sop;
                    out_eop  <= 1'b1;
                    out_mty  <= MTY_HALF + {1'b0, in_mty};
                    lo_vld   <= 1'b0;
                end else begin
                    lo_reg <= in_data;
                    lo_sop <= in_sop;
                    lo_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_demux_p.sv
// Three-way packet demultiplexer with per-channel width conversion.
// Optional per-channel packet counters: define FIFO_DEMUX_CNT_EN.
module fifo_demux_p
    import fifo_demux_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W_B-1:0] din,
    input  logic           din_sop,
    input  logic           din_eop,
    input  logic           din_mty,
    input  logic           din_vld,
    input  logic [1:0]     din_chan,
    output logic           din_rdy,
    output logic [W_A-1:0] data_a,
    output logic           data_a_sop,
    output logic           data_a_eop,
    output logic           data_a_vld,
    output logic [W_B-1:0] data_b,
    output logic           data_b_sop,
    output logic           data_b_eop,
    output logic           data_b_mty,
    output logic           data_b_vld,
    output logic [W_C-1:0] data_c,
    output logic           data_c_sop,
    output logic           data_c_eop,
    output logic           data_c_vld,
    output logic [1:0]     data_c_mty,
    output logic           err
`ifdef FIFO_DEMUX_CNT_EN
    ,
    output logic [15:0]    pkt_cnt_a,
    output logic [15:0]    pkt_cnt_b,
    output logic [15:0]    pkt_cnt_c
`endif
);

    chan_e          cur_chan;
    chan_e          eff_chan;
    logic           in_pkt;
    logic           hi_pend;
    logic [W_A-1:0] hi_byte;
    logic           hi_eop;
    logic           accept;
    logic           beat_ok;
    logic           overlap;
    logic           stray;
    logic           bad_sop;
    logic           take_a;
    logic           take_b;
    logic           take_c;

    assign din_rdy = !hi_pend;
    assign accept  = din_vld && din_rdy;

    // Beat classification: destination channel and protocol-error conditions.
    always_comb begin
        eff_chan = din_sop ? chan_e'(din_chan) : cur_chan;
        beat_ok  = accept && (din_sop || in_pkt);
        overlap  = accept && din_sop && in_pkt;
        stray    = accept && !din_sop && !in_pkt;
        bad_sop  = accept && din_sop && (chan_e'(din_chan) == CHAN_BAD);
        take_a   = beat_ok && (eff_chan == CHAN_A);
        take_b   = beat_ok && (eff_chan == CHAN_B);
        take_c   = beat_ok && (eff_chan == CHAN_C);
    end

    // Packet tracking: sop latches the channel, eop closes the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_chan <= CHAN_A;
            in_pkt   <= 1'b0;
        end else if (accept) begin
            if (din_sop) begin
                cur_chan <= chan_e'(din_chan);
                in_pkt   <= !din_eop;
            end else if (in_pkt && din_eop) begin
                in_pkt <= 1'b0;
            end
        end
    end

    // Channel 0: low byte on the accept cycle, high byte one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a     <= '0;
            data_a_sop <= 1'b0;
            data_a_eop <= 1'b0;
            data_a_vld <= 1'b0;
            hi_pend    <= 1'b0;
            hi_byte    <= '0;
            hi_eop     <= 1'b0;
        end else begin
            data_a_vld <= 1'b0;
            data_a_sop <= 1'b0;
            data_a_eop <= 1'b0;
            if (hi_pend) begin
                data_a     <= hi_byte;
                data_a_vld <= 1'b1;
                data_a_eop <= hi_eop;
                hi_pend    <= 1'b0;
            end else if (take_a) begin
                data_a     <= din[W_A-1:0];
                data_a_vld <= 1'b1;
                data_a_sop <= din_sop;
                data_a_eop <= din_eop && din_mty;
                if (!(din_eop && din_mty)) begin
                    hi_pend <= 1'b1;
                    hi_byte <= din[W_B-1:W_A];
                    hi_eop  <= din_eop;
                end
            end
        end
    end

    // Channel 1: registered passthrough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_b     <= '0;
            data_b_sop <= 1'b0;
            data_b_eop <= 1'b0;
            data_b_mty <= 1'b0;
            data_b_vld <= 1'b0;
        end else begin
            data_b_vld <= 1'b0;
            data_b_sop <= 1'b0;
            data_b_eop <= 1'b0;
            if (take_b) begin
                data_b     <= din;
                data_b_vld <= 1'b1;
                data_b_sop <= din_sop;
                data_b_eop <= din_eop;
                data_b_mty <= din_mty;
            end
        end
    end

    // Protocol-error pulse, aligned with the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= overlap || stray || bad_sop;
        end
    end

    // A sop inside an open packet aborts any half-word held by the packer.
    fifo_demux_pack32 u_pack32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (take_c),
        .in_data  (din),
        .in_sop   (din_sop),
        .in_eop   (din_eop),
        .in_mty   (din_mty),
        .flush    (overlap),
        .out_data (data_c),
        .out_sop  (data_c_sop),
        .out_eop  (data_c_eop),
        .out_mty  (data_c_mty),
        .out_vld  (data_c_vld)
    );

`ifdef FIFO_DEMUX_CNT_EN
    // Per-channel packet counters, stepped on each emitted eop, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_a <= '0;
            pkt_cnt_b <= '0;
            pkt_cnt_c <= '0;
        end else begin
            if (data_a_vld && data_a_eop) pkt_cnt_a <= pkt_cnt_a + 16'd1;
            if (data_b_vld && data_b_eop) pkt_cnt_b <= pkt_cnt_b + 16'd1;
            if (data_c_vld && data_c_eop) pkt_cnt_c <= pkt_cnt_c + 16'd1;
        end
    end
`endif

endmodule
